// File: rtl/rate_counter.sv
// rate_counter: 4-bit hex digit counter advanced by a selectable-rate divider.
//
// A down-counter (rd) divides the clock by the period P chosen by rate_sel
// (1, CLK_HZ, 2*CLK_HZ or 4*CLK_HZ cycles). Each time rd expires while
// enabled, q steps by one (mod 16) and tick pulses; wrap pulses together with
// tick when q rolls over. load has priority over counting and restarts the
// divider. A change of rate_sel restarts the divider without a tick.
//
// Ports:
//   clock     in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   enable    in   1 = divider and counter advance, 0 = hold
//   rate_sel  in   [1:0] tick period select
//   load      in   synchronous parallel load of q
//   load_val  in   [3:0] value loaded into q
//   dir       in   0 = up, 1 = down (only with RATE_COUNTER_DOWN_EN)
//   q         out  [3:0] current digit, registered
//   tick      out  one-cycle pulse when q shows a counted value
//   wrap      out  one-cycle pulse when q shows a wrapped value
//
// Build option: define RATE_COUNTER_DOWN_EN to honour dir; otherwise dir is
// ignored and the counter always counts up.

module rate_counter #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dir,
    output logic [3:0] q,
    output logic       tick,
    output logic       wrap
);

    localparam int unsigned RD_W = $clog2(4 * CLK_HZ);

    localparam logic [RD_W-1:0] RELOAD_SEL0 = '0;
    localparam logic [RD_W-1:0] RELOAD_SEL1 = RD_W'(CLK_HZ - 1);
    localparam logic [RD_W-1:0] RELOAD_SEL2 = RD_W'((2 * CLK_HZ) - 1);
    localparam logic [RD_W-1:0] RELOAD_SEL3 = RD_W'((4 * CLK_HZ) - 1);

    logic [RD_W-1:0] rd_q, rd_d;
    logic [3:0]      q_q, q_d;
    logic            tick_q, tick_d;
    logic            wrap_q, wrap_d;
    logic [1:0]      sel_q, sel_d;

    logic [RD_W-1:0] reload_c;
    logic            count_down_c;
    logic [3:0]      q_step_c;
    logic            wrap_hit_c;

    // Direction source depends on the build option.
`ifdef RATE_COUNTER_DOWN_EN
    assign count_down_c = dir;
`else
    logic dir_unused;
    assign dir_unused   = dir;
    assign count_down_c = 1'b0;
`endif

    // Divider reload value P-1 for the currently requested rate.
    always_comb begin
        reload_c = RELOAD_SEL0;
        case (rate_sel)
            2'b00:   reload_c = RELOAD_SEL0;
            2'b01:   reload_c = RELOAD_SEL1;
            2'b10:   reload_c = RELOAD_SEL2;
            2'b11:   reload_c = RELOAD_SEL3;
            default: reload_c = RELOAD_SEL0;
        endcase
    end

    // Next digit and rollover detection for one counting step.
    always_comb begin
        q_step_c   = q_q + 4'd1;
        wrap_hit_c = (q_q == 4'hF);
        if (count_down_c) begin
            q_step_c   = q_q - 4'd1;
            wrap_hit_c = (q_q == 4'h0);
        end
    end

    // Next-state: load beats a rate change, which beats normal counting.
    always_comb begin
        rd_d   = rd_q;
        q_d    = q_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        sel_d  = rate_sel;

        if (load) begin
            q_d  = load_val;
            rd_d = reload_c;
        end else if (rate_sel != sel_q) begin
            // New rate: restart the divider, no step this cycle.
            rd_d = reload_c;
        end else if (enable) begin
            if (rd_q == '0) begin
                rd_d   = reload_c;
                q_d    = q_step_c;
                tick_d = 1'b1;
                wrap_d = wrap_hit_c;
            end else begin
                rd_d = rd_q - RD_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q   <= reload_c;
            q_q    <= 4'h0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            sel_q  <= rate_sel;
        end else begin
            rd_q   <= rd_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            sel_q  <= sel_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_rate_counter.sv
// Testbench for rate_counter (CLK_HZ = 4): directed scenarios followed by
// random stimulus, checked every cycle against a reference model through a
// scoreboard queue, plus absolute spot checks on the directed scenarios.

module tb_rate_counter;

    localparam int unsigned CLK_HZ = 4;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [1:0] rate_sel;
    logic       load;
    logic [3:0] load_val;
    logic       dir;
    logic [3:0] q;
    logic       tick;
    logic       wrap;

    rate_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .rate_sel (rate_sel),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .q        (q),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] q;
        logic       tick;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle_no = 0;

    // Reference model: elapsed enabled cycles since the divider last restarted.
    int m_q       = 0;
    int m_elapsed = 0;
    int m_sel     = 0;

    function automatic int period(input int sel);
        if (sel == 0) return 1;
        return CLK_HZ * (1 << (sel - 1));
    endfunction

    function automatic exp_t model_step(input bit r, input bit en, input int sel,
                                        input bit ld, input int lv, input bit d);
        exp_t e;
        bit   down;
        int   old;
`ifdef RATE_COUNTER_DOWN_EN
        down = d;
`else
        down = 1'b0;
        if (d) down = 1'b0;
`endif
        e.tick = 1'b0;
        e.wrap = 1'b0;
        if (r) begin
            m_q = 0;
            m_elapsed = 0;
        end else if (ld) begin
            m_q = lv;
            m_elapsed = 0;
        end else if (sel != m_sel) begin
            m_elapsed = 0;
        end else if (en) begin
            if (m_elapsed + 1 == period(sel)) begin
                old = m_q;
                m_q = down ? (m_q + 15) % 16 : (m_q + 1) % 16;
                m_elapsed = 0;
                e.tick = 1'b1;
                e.wrap = down ? (old == 0) : (old == 15);
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end
        m_sel = sel;
        e.q = 4'(m_q);
        return e;
    endfunction

    // Apply one cycle of inputs, queue the expected result, settle after the edge.
    task automatic drive(input bit r, input bit en, input int sel,
                         input bit ld, input int lv, input bit d);
        @(negedge clock);
        reset    = r;
        enable   = en;
        rate_sel = 2'(sel);
        load     = ld;
        load_val = 4'(lv);
        dir      = d;
        sb.push_back(model_step(r, en, sel, ld, lv, d));
        @(posedge clock);
        #3;
    endtask

    task automatic spot(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per clock and compares all outputs.
    always begin
        @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            cycle_no++;
            checks++;
            if (q !== e.q || tick !== e.tick || wrap !== e.wrap) begin
                errors++;
                $display("FAIL sb_cycle%0d: got q=%0h tick=%0b wrap=%0b expected q=%0h tick=%0b wrap=%0b",
                         cycle_no, q, tick, wrap, e.q, e.tick, e.wrap);
            end
        end
    end

    initial begin
        int tick_cnt;
        int wait_cnt;
        reset    = 1'b1;
        enable   = 1'b0;
        rate_sel = 2'b01;
        load     = 1'b0;
        load_val = 4'h0;
        dir      = 1'b0;

        // Reset for two cycles.
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0);
        spot("reset_q", int'(q), 0);
        spot("reset_tick", int'(tick), 0);
        spot("reset_wrap", int'(wrap), 0);

        // Divided counting at rate 01: tick every 4th cycle.
        tick_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            tick_cnt += int'(tick);
            spot("div_wrap", int'(wrap), 0);
            spot("div_tick_phase", int'(tick), ((i % 4) == 3) ? 1 : 0);
        end
        spot("div_q", int'(q), 3);
        spot("div_tick_count", tick_cnt, 3);

        // Up-wrap after load of F at full rate.
        drive(0, 1, 0, 1, 15, 0);
        spot("load_f_q", int'(q), 15);
        drive(0, 1, 0, 0, 0, 0);
        spot("upwrap_q", int'(q), 0);
        spot("upwrap_tick", int'(tick), 1);
        spot("upwrap_wrap", int'(wrap), 1);

        // Hold: 2 enabled, 5 disabled, tick on 2nd enabled cycle after.
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 0, 0, 0);
            spot("hold_q", int'(q), 0);
            spot("hold_tick", int'(tick), 0);
        end
        drive(0, 1, 1, 0, 0, 0);
        spot("reen1_tick", int'(tick), 0);
        drive(0, 1, 1, 0, 0, 0);
        spot("reen2_tick", int'(tick), 1);
        spot("reen2_q", int'(q), 1);

        // Load collides with a due tick.
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 7, 0);
        spot("collide_q", int'(q), 7);
        spot("collide_tick", int'(tick), 0);

        // Direction.
        drive(0, 1, 0, 1, 0, 0);
        drive(0, 1, 0, 0, 0, 1);
`ifdef RATE_COUNTER_DOWN_EN
        spot("dir_q", int'(q), 15);
        spot("dir_wrap", int'(wrap), 1);
`else
        spot("dir_q", int'(q), 1);
        spot("dir_wrap", int'(wrap), 0);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            bit r, en, ld, d;
            int sel;
            r   = ($urandom_range(99, 0) < 2);
            ld  = ($urandom_range(99, 0) < 5);
            en  = ($urandom_range(99, 0) < 80);
            d   = 1'($urandom_range(1, 0));
            sel = ($urandom_range(99, 0) < 5) ? int'($urandom_range(3, 0)) : m_sel;
            drive(r, en, sel, ld, int'($urandom_range(15, 0)), d);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 10) begin
            @(posedge clock);
            #4;
            wait_cnt++;
        end
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rate_counter.md
RATE_COUNTER -- requirements
Module: rate_counter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz (>=1); sets the divider periods.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  1 = divider and counter advance; 0 = hold all state.
REQ-005 SHALL have port rate_sel  input  2  tick period: 00 = 1 cycle, 01 = CLK_HZ, 10 = 2*CLK_HZ, 11 = 4*CLK_HZ cycles.
REQ-006 SHALL have port load  input  1  synchronous parallel load of the counter.
REQ-007 SHALL have port load_val  input  4  value loaded into q when load=1.
REQ-008 SHALL have port dir  input  1  0 = count up, 1 = count down (see Configuration).
REQ-009 SHALL have port q  output  4  current hex digit, registered; drives the 7-segment decoder nibble input.
REQ-010 SHALL have port tick  output  1  registered one-cycle pulse, high in the cycle q shows a counted value.
REQ-011 SHALL have port wrap  output  1  registered one-cycle pulse, high in the cycle q shows a wrapped value (F->0 up, 0->F down).

Function
REQ-012 SHALL implement a down-counter rd, width clog2(4*CLK_HZ), reload value P-1, where P is the period selected by rate_sel.
REQ-013 SHALL, when enable=1 and rd=0, reload rd to P-1, step q by one mod 16, and set tick=1 on that edge.
REQ-014 SHALL, when enable=1 and rd!=0, decrement rd, hold q, and clear tick and wrap.
REQ-015 SHALL, when enable=0, hold rd and q and clear tick and wrap.
REQ-016 SHALL, with rate_sel=00, tick on every enabled cycle (rd held at 0).
REQ-017 SHALL set wrap=1 on the same edge as tick when q goes F->0 (up) or 0->F (down); otherwise wrap=0.
REQ-018 SHALL give load priority over counting: load=1 sets q=load_val, reloads rd to P-1, clears tick and wrap, and ignores enable.
REQ-019 SHALL register rate_sel internally; on a cycle where rate_sel differs from the registered value, rd SHALL reload to the new P-1 with no tick that cycle.
REQ-020 SHALL treat q arithmetic as 4-bit modulo 16; no saturation.
REQ-021 SHALL make q, tick, and wrap change only on a clock edge; there are no combinational paths from inputs to outputs.

Reset
REQ-022 SHALL give reset=1 priority over all inputs: q=0, tick=0, wrap=0, rd=P(rate_sel)-1, registered rate_sel=rate_sel.
REQ-023 SHALL, when reset is asserted mid-count, discard the partial divider count; the first tick after release comes P enabled cycles later.

Configuration
REQ-024 SHALL honour dir, when macro RATE_COUNTER_DOWN_EN is defined: dir=1 decrements q and wraps 0->F.
REQ-025 SHALL, when RATE_COUNTER_DOWN_EN is undefined, ignore dir and always count up; the dir port still exists.

Verification (CLK_HZ=4 in bench)
REQ-026 SHALL cover reset: reset=1 for 2 cycles -> q=0, tick=0, wrap=0.
REQ-027 SHALL cover divided counting: rate_sel=01, enable=1, 12 cycles -> q steps 0->1->2->3, one tick every 4th cycle, wrap=0.
REQ-028 SHALL cover up-wrap with load: rate_sel=00, load=1 with load_val=F, then load=0 -> next cycle q=0, tick=1, wrap=1.
REQ-029 SHALL cover hold: rate_sel=01, enable dropped for 5 cycles after 2 enabled cycles -> q and tick frozen; the tick arrives 2 enabled cycles after re-enable.
REQ-030 SHALL cover load/tick collision: load=1 with load_val=7 on a cycle where rd=0 -> q=7, tick=0.
REQ-031 SHALL cover direction: load 0, dir=1, rate_sel=00 -> q=F with wrap=1 when RATE_COUNTER_DOWN_EN is defined; q=1 with wrap=0 when undefined.
